// File: rtl/zcmp_macro_sequencer_pkg.sv
// Core configuration subset and Zcmp sequencer types, opcode constants and encoders.
// Optional build macro: CVA6_ZCMP_ILLEGAL_REPORT_EN adds the ST_ILL state.
package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        logic        RVZCMP;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_default = '{XLEN: 32, RVZCMP: 1'b1};
endpackage

package zcmp_macro_sequencer_pkg;
    typedef enum logic [2:0] {
        ZCMP_NONE,
        ZCMP_PUSH,
        ZCMP_POP,
        ZCMP_POPRETZ,
        ZCMP_POPRET,
        ZCMP_MVSA01,
        ZCMP_MVA01S
    } zcmp_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_ZERO_A0,
        ST_ADJ_SP,
        ST_RET,
        ST_MV
`ifdef CVA6_ZCMP_ILLEGAL_REPORT_EN
        , ST_ILL
`endif
    } zcmp_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_DWORD   = 3'b011;
    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_RA     = 5'd1;
    localparam logic [4:0] REG_SP     = 5'd2;
    localparam logic [4:0] REG_A0     = 5'd10;
    localparam logic [4:0] REG_A1     = 5'd11;

    // Compressed s-register field: 0,1 -> s0,s1 (x8,x9); 2..7 -> s2..s7 (x18..x23).
    function automatic logic [4:0] sreg_map(input logic [2:0] r);
        return (r < 3'd2) ? (5'd8 + {2'b00, r}) : (5'd16 + {2'b00, r});
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction
endpackage

// File: rtl/zcmp_macro_sequencer_reglist_decode.sv
// Register-list decode: slot index to register number, list length, stack adjustment
// and per-slot byte offset for the current XLEN.
module zcmp_reglist_decode #(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]  rlist_i,
    input  logic [1:0]  spimm_i,
    input  logic [3:0]  index_i,
    output logic [4:0]  reg_o,
    output logic [3:0]  n_o,
    output logic [11:0] stack_adj_o,
    output logic [11:0] slot_off_o
);
    localparam int unsigned SH = (XLEN == 64) ? 3 : 2;

    logic [11:0] bytes;
    logic [11:0] base;

    always_comb begin
        // rlist 15 covers s10 and s11 together, so the count jumps from 11 to 13.
        n_o         = (rlist_i == 4'd15) ? 4'd13 : (rlist_i - 4'd3);
        bytes       = {8'd0, n_o} << SH;
        base        = (bytes + 12'd15) & 12'hFF0;
        stack_adj_o = base + {6'd0, spimm_i, 4'd0};
        slot_off_o  = ({8'd0, index_i} + 12'd1) << SH;
        case (index_i)
            4'd0:    reg_o = 5'd1;
            4'd1:    reg_o = 5'd8;
            4'd2:    reg_o = 5'd9;
            default: reg_o = {1'b0, index_i} + 5'd15;
        endcase
    end
endmodule

// File: rtl/zcmp_macro_sequencer.sv
// Zcmp macro expander: turns cm.push/pop/popret/popretz/mvsa01/mva01s into base-ISA
// micro-ops; everything else passes through. Optional macro: CVA6_ZCMP_ILLEGAL_REPORT_EN.
module zcmp_macro_sequencer
    import zcmp_macro_sequencer_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_default
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic        is_compressed_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        is_macro_o,
    output logic        is_last_o,
    output logic        illegal_o
);
    if (CVA6Cfg.RVZCMP) begin : g_seq
        localparam logic [2:0] F3_MEM = (CVA6Cfg.XLEN == 64) ? F3_DWORD : F3_WORD;

        zcmp_state_e state_q, state_d;
        zcmp_op_e    op_q, op_d, dec_op;
        logic [3:0]  idx_q, idx_d;
        logic [3:0]  rlist_q, rlist_d;
        logic [1:0]  spimm_q, spimm_d;
        logic [2:0]  r1s_q, r1s_d, r2s_q, r2s_d;
`ifdef CVA6_ZCMP_ILLEGAL_REPORT_EN
        logic [15:0] raw_q, raw_d;
`endif

        logic        reserved, zcmp_take;
        logic [31:0] beat_instr;
        logic        last_beat, illegal_beat;
        logic [4:0]  mem_reg, sreg, areg;
        logic [3:0]  n_regs;
        logic [11:0] stack_adj, slot_off;

        zcmp_reglist_decode #(.XLEN(CVA6Cfg.XLEN)) u_reglist (
            .rlist_i     (rlist_q),
            .spimm_i     (spimm_q),
            .index_i     (idx_q),
            .reg_o       (mem_reg),
            .n_o         (n_regs),
            .stack_adj_o (stack_adj),
            .slot_off_o  (slot_off)
        );

        always_comb begin
            dec_op = ZCMP_NONE;
            if (is_compressed_i && instr_i[1:0] == 2'b10 && instr_i[15:13] == 3'b101) begin
                case (instr_i[12:8])
                    5'b11000: dec_op = ZCMP_PUSH;
                    5'b11010: dec_op = ZCMP_POP;
                    5'b11100: dec_op = ZCMP_POPRETZ;
                    5'b11110: dec_op = ZCMP_POPRET;
                    default: begin
                        if (instr_i[12:10] == 3'b011 && instr_i[6:5] == 2'b01) dec_op = ZCMP_MVSA01;
                        if (instr_i[12:10] == 3'b011 && instr_i[6:5] == 2'b11) dec_op = ZCMP_MVA01S;
                    end
                endcase
            end
            reserved = 1'b0;
            if (dec_op == ZCMP_MVSA01 || dec_op == ZCMP_MVA01S)
                reserved = (instr_i[9:7] == instr_i[4:2]);
            else if (dec_op != ZCMP_NONE)
                reserved = (instr_i[7:4] < 4'd4);
`ifdef CVA6_ZCMP_ILLEGAL_REPORT_EN
            zcmp_take = (dec_op != ZCMP_NONE);
`else
            // Reserved encodings flow through so the main decoder raises the exception.
            zcmp_take = (dec_op != ZCMP_NONE) && !reserved;
`endif
        end

        always_comb begin
            state_d = state_q;
            op_d    = op_q;
            idx_d   = idx_q;
            rlist_d = rlist_q;
            spimm_d = spimm_q;
            r1s_d   = r1s_q;
            r2s_d   = r2s_q;
`ifdef CVA6_ZCMP_ILLEGAL_REPORT_EN
            raw_d   = raw_q;
`endif
            beat_instr   = '0;
            last_beat    = 1'b0;
            illegal_beat = 1'b0;
            sreg         = sreg_map(idx_q[0] ? r2s_q : r1s_q);
            areg         = idx_q[0] ? REG_A1 : REG_A0;

            case (state_q)
                ST_MEM: begin
                    if (op_q == ZCMP_PUSH)
                        beat_instr = enc_s(12'd0 - slot_off, mem_reg, REG_SP, F3_MEM);
                    else
                        beat_instr = enc_i(stack_adj - slot_off, REG_SP, F3_MEM, mem_reg, OPC_LOAD);
                end
                ST_ZERO_A0: beat_instr = enc_i(12'd0, REG_ZERO, F3_ADDI, REG_A0, OPC_OP_IMM);
                ST_ADJ_SP: begin
                    beat_instr = enc_i((op_q == ZCMP_PUSH) ? (12'd0 - stack_adj) : stack_adj,
                                       REG_SP, F3_ADDI, REG_SP, OPC_OP_IMM);
                    last_beat  = (op_q == ZCMP_PUSH) || (op_q == ZCMP_POP);
                end
                ST_RET: begin
                    beat_instr = enc_i(12'd0, REG_RA, F3_JALR, REG_ZERO, OPC_JALR);
                    last_beat  = 1'b1;
                end
                ST_MV: begin
                    beat_instr = (op_q == ZCMP_MVSA01) ?
                                 enc_i(12'd0, areg, F3_ADDI, sreg, OPC_OP_IMM) :
                                 enc_i(12'd0, sreg, F3_ADDI, areg, OPC_OP_IMM);
                    last_beat  = idx_q[0];
                end
`ifdef CVA6_ZCMP_ILLEGAL_REPORT_EN
                ST_ILL: begin
                    beat_instr   = {16'd0, raw_q};
                    last_beat    = 1'b1;
                    illegal_beat = 1'b1;
                end
`endif
                default: ;
            endcase

            if (state_q == ST_IDLE) begin
                if (zcmp_take && valid_i && !flush_i) begin
                    op_d    = dec_op;
                    idx_d   = 4'd0;
                    rlist_d = instr_i[7:4];
                    spimm_d = instr_i[3:2];
                    r1s_d   = instr_i[9:7];
                    r2s_d   = instr_i[4:2];
                    state_d = (dec_op == ZCMP_MVSA01 || dec_op == ZCMP_MVA01S) ? ST_MV : ST_MEM;
`ifdef CVA6_ZCMP_ILLEGAL_REPORT_EN
                    raw_d   = instr_i[15:0];
                    if (reserved) state_d = ST_ILL;
`endif
                end
            end else if (flush_i || (ready_i && last_beat)) begin
                state_d = ST_IDLE;
                op_d    = ZCMP_NONE;
                idx_d   = 4'd0;
            end else if (ready_i) begin
                case (state_q)
                    ST_MEM: begin
                        if (idx_q == n_regs - 4'd1) begin
                            idx_d   = 4'd0;
                            state_d = (op_q == ZCMP_POPRETZ) ? ST_ZERO_A0 : ST_ADJ_SP;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                    ST_ZERO_A0: state_d = ST_ADJ_SP;
                    ST_ADJ_SP:  state_d = ST_RET;
                    ST_MV:      idx_d   = idx_q + 4'd1;
                    default: ;
                endcase
            end
        end

        always_comb begin
            ready_o    = 1'b0;
            valid_o    = 1'b0;
            instr_o    = '0;
            is_macro_o = 1'b0;
            is_last_o  = 1'b0;
            illegal_o  = 1'b0;
            if (!rst_i) begin
                if (state_q == ST_IDLE) begin
                    if (zcmp_take) begin
                        ready_o = 1'b1;
                    end else begin
                        valid_o = valid_i;
                        instr_o = instr_i;
                        ready_o = ready_i;
                    end
                end else begin
                    valid_o    = 1'b1;
                    instr_o    = beat_instr;
                    is_macro_o = 1'b1;
                    is_last_o  = last_beat;
                    illegal_o  = illegal_beat;
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                op_q    <= ZCMP_NONE;
                idx_q   <= '0;
                rlist_q <= '0;
                spimm_q <= '0;
                r1s_q   <= '0;
                r2s_q   <= '0;
`ifdef CVA6_ZCMP_ILLEGAL_REPORT_EN
                raw_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                op_q    <= op_d;
                idx_q   <= idx_d;
                rlist_q <= rlist_d;
                spimm_q <= spimm_d;
                r1s_q   <= r1s_d;
                r2s_q   <= r2s_d;
`ifdef CVA6_ZCMP_ILLEGAL_REPORT_EN
                raw_q   <= raw_d;
`endif
            end
        end
    end else begin : g_pass
        logic unused_pass;
        assign unused_pass = clk_i ^ flush_i ^ is_compressed_i;
        assign ready_o     = !rst_i && ready_i;
        assign valid_o     = !rst_i && valid_i;
        assign instr_o     = rst_i ? 32'd0 : instr_i;
        assign is_macro_o  = 1'b0;
        assign is_last_o   = 1'b0;
        assign illegal_o   = 1'b0;
    end
endmodule
